// File: rtl/l2_store_merge_buffer_pkg.sv
// l2_store_merge_buffer_pkg: LC-3b bus types plus store-buffer entry and sequencer state
package l2_store_merge_buffer_pkg;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;
    typedef logic [3:0]   lc3b_cache_offset;
    typedef struct packed {
        lc3b_word   addr;
        lc3b_word   data;
        logic [1:0] be;
    } l2_store_entry;
    typedef enum logic [1:0] {SMB_IDLE, SMB_READ, SMB_WRITE} l2_smb_state_t;
endpackage

// File: rtl/replace_word_l2.sv
// replace_word_l2: overlays the enabled bytes of a 16-bit word onto a 128-bit line
module replace_word_l2
    import l2_store_merge_buffer_pkg::*;
(
    input  lc3b_burst        i_line,
    input  lc3b_cache_offset i_offset,
    input  lc3b_word         i_word,
    input  logic [1:0]       i_be,
    output lc3b_burst        o_line
);
    logic w_unused;
    assign w_unused = i_offset[0];
    for (genvar b = 0; b < 16; b++) begin : g_byte
        assign o_line[b*8 +: 8] = (i_offset[3:1] == 3'(b / 2) && i_be[b % 2]) ? i_word[(b % 2)*8 +: 8] : i_line[b*8 +: 8];
    end
endmodule

// File: rtl/l2_store_merge_buffer.sv
// l2_store_merge_buffer: FIFO of L1 stores, each retired as a read-modify-write of its L2 line
module l2_store_merge_buffer
    import l2_store_merge_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_write,
    input  lc3b_word    i_req_address,
    input  lc3b_word    i_req_wdata,
    input  logic [1:0]  i_req_byte_enable,
    output logic        o_req_resp,
    output logic        o_line_read,
    output logic        o_line_write,
    output lc3b_word    o_line_address,
    input  lc3b_burst   i_line_rdata,
    output lc3b_burst   o_line_wdata,
    input  logic        i_line_resp,
    input  lc3b_word    i_snoop_address,
    output logic        o_snoop_hit,
    output logic        o_empty
);
    l2_store_entry r_mem [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   r_count;
    l2_smb_state_t    r_state, w_state_next;
    lc3b_burst        r_wbuf, w_merged;
    l2_store_entry    w_head;
    logic             w_full, w_enq, w_pop, w_unused;

    assign w_unused       = ^i_snoop_address[3:0];
    assign w_head         = r_mem[r_head];
    assign w_full         = r_count == (PTR_W+1)'(DEPTH);
    // Zero byte-enable stores are acknowledged but never queued
    assign o_req_resp     = i_req_write & ~w_full;
    assign w_enq          = o_req_resp & (i_req_byte_enable != 2'b00);
    assign w_pop          = (r_state == SMB_WRITE) & i_line_resp;
    assign o_line_read    = r_state == SMB_READ;
    assign o_line_write   = r_state == SMB_WRITE;
    assign o_line_address = {w_head.addr[15:4], 4'h0};
    assign o_line_wdata   = r_wbuf;
    assign o_empty        = (r_count == '0) & (r_state == SMB_IDLE);
    assign w_state_next   = r_state == SMB_IDLE ? (r_count != '0 ? SMB_READ : SMB_IDLE) :
                            r_state == SMB_READ ? (i_line_resp ? SMB_WRITE : SMB_READ) :
                                                  (i_line_resp ? SMB_IDLE : SMB_WRITE);

    replace_word_l2 u_merge (
        .i_line   (i_line_rdata),
        .i_offset (w_head.addr[3:0]),
        .i_word   (w_head.data),
        .i_be     (w_head.be),
        .o_line   (w_merged)
    );

    // An entry is valid when its distance from head is below count
    always_comb begin
        o_snoop_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            o_snoop_hit = o_snoop_hit | (({1'b0, PTR_W'(i) - r_head} < r_count) && r_mem[PTR_W'(i)].addr[15:4] == i_snoop_address[15:4]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem   <= '{default: '0};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= SMB_IDLE;
            r_wbuf  <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail] <= '{addr: i_req_address, data: i_req_wdata, be: i_req_byte_enable};
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            if (r_state == SMB_READ && i_line_resp)
                r_wbuf <= w_merged;
            r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_pop);
            r_state <= w_state_next;
        end
    end
endmodule
